// File: rtl/regimm_resolve_if.sv
// regimm_resolve_if
// -----------------------------------------------------------------------------
// Bundles the ID->EX instruction handshake and the EX->MEM result handshake of
// the REGIMM resolver into one interface.
//
// Parameter:
//   PC_W            width of PC, branch target and link value
//
// Signals (direction as seen by the resolver, modport slave):
//   in_valid        in   upstream instruction valid
//   in_ready        out  resolver can accept this cycle
//   in_is_regimm    in   instruction is a REGIMM opcode (0 = passthrough)
//   in_rt           in   REGIMM rt sub-op code
//   in_rs           in   forwarded rs operand
//   in_imm          in   16-bit immediate field
//   in_pc           in   instruction PC
//   out_valid       out  result valid
//   out_ready       in   downstream accepts
//   out_taken       out  branch taken
//   out_target      out  branch target
//   out_link_we     out  write out_link_value to GPR31
//   out_link_value  out  in_pc + 8
//   out_trap        out  trap condition true
//   out_reserved    out  reserved-instruction exception
//   out_kill        out  entry is an annulled delay slot
//
// Modports: slave = resolver side, master = upstream/downstream side.
`timescale 1ns/1ps

interface regimm_resolve_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            in_is_regimm;
    logic [4:0]      in_rt;
    logic [31:0]     in_rs;
    logic [15:0]     in_imm;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic [PC_W-1:0] out_target;
    logic            out_link_we;
    logic [PC_W-1:0] out_link_value;
    logic            out_trap;
    logic            out_reserved;
    logic            out_kill;

    modport slave (
        input  in_valid, in_is_regimm, in_rt, in_rs, in_imm, in_pc, out_ready,
        output in_ready, out_valid, out_taken, out_target, out_link_we,
               out_link_value, out_trap, out_reserved, out_kill
    );

    modport master (
        output in_valid, in_is_regimm, in_rt, in_rs, in_imm, in_pc, out_ready,
        input  in_ready, out_valid, out_taken, out_target, out_link_we,
               out_link_value, out_trap, out_reserved, out_kill
    );
endinterface

// File: rtl/regimm_resolve.sv
// regimm_resolve
// -----------------------------------------------------------------------------
// Execute-stage resolver for MIPS REGIMM instructions (opcode 000001, class in
// rt). Every instruction flowing ID->EX passes through; REGIMM ones get their
// branch direction/target, link write-back, trap condition and reserved
// status resolved, and branch-likely delay slots are marked for annulment.
// Results leave through a 2-entry skid buffer (main + skid register).
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   flush     synchronous pipeline flush, drops both buffered entries and
//             any pending delay-slot state; input is not accepted that cycle
//   bus       regimm_resolve_if.slave, instruction in / result out handshake
//
// Configuration macro:
//   REGIMM_TRAP_EN  defined   -> TGEI/TGEIU/TLTI/TLTIU/TEQI/TNEI evaluated
//                   undefined -> those codes raise out_reserved, out_trap = 0
//
// PC_W must match the PC_W of the connected interface and be at least 18.
`timescale 1ns/1ps

module regimm_resolve #(
    parameter int PC_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    regimm_resolve_if.slave  bus
);
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [4:0] RT_BLTZL   = 5'b00010;
    localparam logic [4:0] RT_BGEZL   = 5'b00011;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;
    localparam logic [4:0] RT_BLTZALL = 5'b10010;
    localparam logic [4:0] RT_BGEZALL = 5'b10011;
`ifdef REGIMM_TRAP_EN
    localparam logic [4:0] RT_TGEI    = 5'b01000;
    localparam logic [4:0] RT_TGEIU   = 5'b01001;
    localparam logic [4:0] RT_TLTI    = 5'b01010;
    localparam logic [4:0] RT_TLTIU   = 5'b01011;
    localparam logic [4:0] RT_TEQI    = 5'b01100;
    localparam logic [4:0] RT_TNEI    = 5'b01110;
`endif

    typedef enum logic {
        ST_NORMAL,
        ST_SLOT
    } slot_state_t;

    typedef struct packed {
        logic            taken;
        logic [PC_W-1:0] target;
        logic            link_we;
        logic [PC_W-1:0] link_value;
        logic            trap;
        logic            reserved;
        logic            kill;
    } entry_t;

    slot_state_t     slot_state;
    logic            kill_pend;

    entry_t          main_q;
    entry_t          skid_q;
    entry_t          new_entry;
    logic            main_valid;
    logic            skid_valid;

    logic            accept;
    logic            pop;
    logic            is_branch;
    logic            branch_taken;
    logic [PC_W-1:0] imm_off;
`ifdef REGIMM_TRAP_EN
    logic [31:0]     imm32;

    assign imm32 = {{16{bus.in_imm[15]}}, bus.in_imm};
`endif

    // A new entry is taken only while the skid slot is free; flush blocks it.
    assign accept  = bus.in_valid && !skid_valid && !flush;
    assign pop     = main_valid && bus.out_ready;
    assign imm_off = {{(PC_W-18){bus.in_imm[15]}}, bus.in_imm, 2'b00};

    // Resolve the incoming instruction into an output entry. Target and link
    // are always computed so killed or reserved entries still carry them; a
    // branch seen while a delay slot is open is itself illegal and becomes
    // reserved without taking or linking.
    always_comb begin
        new_entry            = '0;
        new_entry.target     = bus.in_pc + PC_W'(4) + imm_off;
        new_entry.link_value = bus.in_pc + PC_W'(8);
        is_branch            = 1'b0;
        branch_taken         = 1'b0;

        if (bus.in_is_regimm) begin
            case (bus.in_rt)
                RT_BLTZ, RT_BLTZL, RT_BLTZAL, RT_BLTZALL: begin
                    is_branch    = 1'b1;
                    branch_taken = $signed(bus.in_rs) < 32'sd0;
                end
                RT_BGEZ, RT_BGEZL, RT_BGEZAL, RT_BGEZALL: begin
                    is_branch    = 1'b1;
                    branch_taken = $signed(bus.in_rs) >= 32'sd0;
                end
`ifdef REGIMM_TRAP_EN
                RT_TGEI:  new_entry.trap = $signed(bus.in_rs) >= $signed(imm32);
                RT_TGEIU: new_entry.trap = bus.in_rs >= imm32;
                RT_TLTI:  new_entry.trap = $signed(bus.in_rs) < $signed(imm32);
                RT_TLTIU: new_entry.trap = bus.in_rs < imm32;
                RT_TEQI:  new_entry.trap = bus.in_rs == imm32;
                RT_TNEI:  new_entry.trap = bus.in_rs != imm32;
`endif
                default:  new_entry.reserved = 1'b1;
            endcase

            if (is_branch) begin
                if (slot_state == ST_SLOT) begin
                    new_entry.reserved = 1'b1;
                end else begin
                    new_entry.taken   = branch_taken;
                    new_entry.link_we = bus.in_rt[4];
                end
            end
        end

        new_entry.kill = (slot_state == ST_SLOT) && kill_pend;
    end

    // Delay-slot tracker: a branch accepted in NORMAL opens the slot and
    // remembers whether it is a not-taken likely branch (rt[1] marks the
    // likely forms); whatever is accepted next closes it again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_state <= ST_NORMAL;
            kill_pend  <= 1'b0;
        end else if (flush) begin
            slot_state <= ST_NORMAL;
            kill_pend  <= 1'b0;
        end else if (accept) begin
            if (slot_state == ST_SLOT) begin
                slot_state <= ST_NORMAL;
                kill_pend  <= 1'b0;
            end else if (is_branch) begin
                slot_state <= ST_SLOT;
                kill_pend  <= bus.in_rt[1] && !branch_taken;
            end
        end
    end

    // Two-entry skid buffer. The skid register only fills while main is
    // stalled, and in_ready is low whenever it is full, so an accept and a
    // skid->main move never happen in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || pop) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= new_entry;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= new_entry;
            skid_valid <= 1'b1;
        end
    end

    assign bus.in_ready       = !skid_valid;
    assign bus.out_valid      = main_valid;
    assign bus.out_taken      = main_q.taken;
    assign bus.out_target     = main_q.target;
    assign bus.out_link_we    = main_q.link_we;
    assign bus.out_link_value = main_q.link_value;
    assign bus.out_trap       = main_q.trap;
    assign bus.out_reserved   = main_q.reserved;
    assign bus.out_kill       = main_q.kill;
endmodule

// File: tb/tb_regimm_resolve.sv
// tb_regimm_resolve
// -----------------------------------------------------------------------------
// Self-checking bench for regimm_resolve. A queue-based reference model holds
// the entries the resolver should currently be buffering; each cycle the
// occupancy, in_ready and the head entry are compared with the DUT. Directed
// steps cover the documented scenarios, followed by a randomized phase.
// Honors REGIMM_TRAP_EN the same way the design does.
`timescale 1ns/1ps

module tb_regimm_resolve;
    localparam int PC_W = 32;

    localparam logic [4:0] BLTZ    = 5'b00000;
    localparam logic [4:0] BGEZ    = 5'b00001;
    localparam logic [4:0] BLTZL   = 5'b00010;
    localparam logic [4:0] BGEZL   = 5'b00011;
    localparam logic [4:0] BLTZAL  = 5'b10000;
    localparam logic [4:0] BGEZAL  = 5'b10001;
    localparam logic [4:0] BLTZALL = 5'b10010;
    localparam logic [4:0] BGEZALL = 5'b10011;
    localparam logic [4:0] TGEI    = 5'b01000;
    localparam logic [4:0] TGEIU   = 5'b01001;
    localparam logic [4:0] TLTI    = 5'b01010;
    localparam logic [4:0] TLTIU   = 5'b01011;
    localparam logic [4:0] TEQI    = 5'b01100;
    localparam logic [4:0] TNEI    = 5'b01110;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic        link_we;
        logic [31:0] link;
        logic        trap;
        logic        reserved;
        logic        kill;
    } entry_t;

    logic   clk = 1'b0;
    logic   reset_n;
    logic   flush;
    int     errors = 0;
    int     checks = 0;
    entry_t expq[$];
    bit     slotOpen = 1'b0;
    bit     slotKill = 1'b0;

    regimm_resolve_if #(.PC_W(PC_W)) bus ();

    regimm_resolve #(.PC_W(PC_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Snapshot of the DUT output fields in model order.
    function automatic entry_t readOut();
        return {bus.out_taken, bus.out_target, bus.out_link_we,
                bus.out_link_value, bus.out_trap, bus.out_reserved, bus.out_kill};
    endfunction

    // Architectural meaning of one instruction, ignoring delay-slot context.
    function automatic entry_t refModel(input logic isr, input logic [4:0] rt,
                                        input logic [31:0] rs, input logic [15:0] imm,
                                        input logic [31:0] pc,
                                        output bit isBranch, output bit likely);
        entry_t      e;
        int          srs;
        int          simm;
        logic [31:0] uimm;
        srs      = rs;
        simm     = $signed(imm);
        uimm     = simm;
        e        = '0;
        isBranch = 1'b0;
        likely   = 1'b0;
        e.target = pc + 32'd4 + 32'(simm * 4);
        e.link   = pc + 32'd8;
        if (isr) begin
            if (rt inside {BLTZ, BLTZL, BLTZAL, BLTZALL, BGEZ, BGEZL, BGEZAL, BGEZALL}) begin
                isBranch  = 1'b1;
                likely    = rt inside {BLTZL, BGEZL, BLTZALL, BGEZALL};
                e.taken   = (rt inside {BLTZ, BLTZL, BLTZAL, BLTZALL}) ? (srs < 0) : (srs >= 0);
                e.link_we = rt inside {BLTZAL, BGEZAL, BLTZALL, BGEZALL};
            end
`ifdef REGIMM_TRAP_EN
            else if (rt == TGEI)  e.trap = srs >= simm;
            else if (rt == TGEIU) e.trap = rs >= uimm;
            else if (rt == TLTI)  e.trap = srs < simm;
            else if (rt == TLTIU) e.trap = rs < uimm;
            else if (rt == TEQI)  e.trap = rs == uimm;
            else if (rt == TNEI)  e.trap = rs != uimm;
`endif
            else e.reserved = 1'b1;
        end
        return e;
    endfunction

    // Push an accepted instruction, applying delay-slot rules.
    task automatic pushEntry(input logic isr, input logic [4:0] rt, input logic [31:0] rs,
                             input logic [15:0] imm, input logic [31:0] pc);
        entry_t e;
        bit     isB;
        bit     lk;
        e = refModel(isr, rt, rs, imm, pc, isB, lk);
        if (slotOpen) begin
            e.kill = slotKill;
            if (isB) begin
                e.reserved = 1'b1;
                e.taken    = 1'b0;
                e.link_we  = 1'b0;
            end
            slotOpen = 1'b0;
            slotKill = 1'b0;
        end else if (isB) begin
            slotOpen = 1'b1;
            slotKill = lk && !e.taken;
        end
        expq.push_back(e);
    endtask

    task automatic checkOutput(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the
    // model by what the handshake rules say happens at the coming edge.
    task automatic applyStimulus(input logic v, input logic isr, input logic [4:0] rt,
                                 input logic [31:0] rs, input logic [15:0] imm,
                                 input logic [31:0] pc, input logic rdy, input logic fl);
        int   occ;
        logic expValid;
        logic expReady;
        bus.in_valid     = v;
        bus.in_is_regimm = isr;
        bus.in_rt        = rt;
        bus.in_rs        = rs;
        bus.in_imm       = imm;
        bus.in_pc        = pc;
        bus.out_ready    = rdy;
        flush            = fl;
        #1;
        occ      = expq.size();
        expValid = (occ != 0);
        expReady = (occ < 2);
        checkOutput("out_valid", {68'd0, bus.out_valid}, {68'd0, expValid});
        checkOutput("in_ready", {68'd0, bus.in_ready}, {68'd0, expReady});
        if (bus.out_valid && occ != 0)
            checkOutput("entry", readOut(), expq[0]);
        if (fl) begin
            expq.delete();
            slotOpen = 1'b0;
            slotKill = 1'b0;
        end else begin
            if (occ != 0 && rdy) void'(expq.pop_front());
            if (v && occ < 2) pushEntry(isr, rt, rs, imm, pc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic isr, input logic [4:0] rt, input logic [31:0] rs,
                         input logic [15:0] imm, input logic [31:0] pc);
        applyStimulus(1'b1, isr, rt, rs, imm, pc, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 16'd0, 32'd0, rdy, 1'b0);
    endtask

    logic [4:0] codes [14] = '{BLTZ, BGEZ, BLTZL, BGEZL, BLTZAL, BGEZAL, BLTZALL,
                               BGEZALL, TGEI, TGEIU, TLTI, TLTIU, TEQI, TNEI};

    initial begin
        logic [4:0]  rRt;
        logic [15:0] rImm;
        logic [31:0] rRs;
        logic [31:0] rPc;
        logic [31:0] sext;
        logic [31:0] tmp;
        int          pick;

        reset_n          = 1'b0;
        flush            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_is_regimm = 1'b0;
        bus.in_rt        = '0;
        bus.in_rs        = '0;
        bus.in_imm       = '0;
        bus.in_pc        = '0;
        bus.out_ready    = 1'b0;

        $display("[TB] reset");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_fields", readOut(), '0);
        checkOutput("reset_valid", {68'd0, bus.out_valid}, 69'd0);
        checkOutput("reset_ready", {68'd0, bus.in_ready}, 69'd1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed: BGEZAL");
        issue(1'b1, BGEZAL, 32'd0, 16'hFFFF, 32'h0040_0000);
        checkOutput("bgezal", readOut(),
                    {1'b1, 32'h0040_0000, 1'b1, 32'h0040_0008, 1'b0, 1'b0, 1'b0});
        issue(1'b0, 5'd0, 32'd7, 16'd3, 32'h0040_0004);

        $display("[TB] directed: likely annul");
        issue(1'b1, BLTZL, 32'd5, 16'h0010, 32'h0000_1000);
        checkOutput("bltzl_taken", {68'd0, bus.out_taken}, 69'd0);
        issue(1'b0, 5'd0, 32'd0, 16'd0, 32'h0000_1004);
        checkOutput("bltzl_kill", {68'd0, bus.out_kill}, 69'd1);
        issue(1'b1, BLTZ, 32'd5, 16'h0010, 32'h0000_1008);
        issue(1'b0, 5'd0, 32'd0, 16'd0, 32'h0000_100C);
        checkOutput("bltz_nokill", {68'd0, bus.out_kill}, 69'd0);

        $display("[TB] directed: traps and reserved");
        issue(1'b1, TLTIU, 32'h0000_0001, 16'hFFFF, 32'h0000_2000);
`ifdef REGIMM_TRAP_EN
        checkOutput("tltiu", {67'd0, bus.out_trap, bus.out_reserved}, 69'b10);
`else
        checkOutput("tltiu", {67'd0, bus.out_trap, bus.out_reserved}, 69'b01);
`endif
        issue(1'b1, TLTI, 32'h0000_0001, 16'hFFFF, 32'h0000_2004);
`ifdef REGIMM_TRAP_EN
        checkOutput("tlti", {67'd0, bus.out_trap, bus.out_reserved}, 69'b00);
`else
        checkOutput("tlti", {67'd0, bus.out_trap, bus.out_reserved}, 69'b01);
`endif
        issue(1'b1, 5'b00100, 32'd0, 16'd0, 32'h0000_2008);
        checkOutput("rt_00100", {68'd0, bus.out_reserved}, 69'd1);
        issue(1'b1, TEQI, 32'hFFFF_8000, 16'h8000, 32'h0000_200C);
`ifdef REGIMM_TRAP_EN
        checkOutput("teqi", {67'd0, bus.out_trap, bus.out_reserved}, 69'b10);
`else
        checkOutput("teqi", {67'd0, bus.out_trap, bus.out_reserved}, 69'b01);
`endif
        idle(1, 1'b1);

        $display("[TB] directed: stall and pc wrap");
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 16'h0004, 32'hFFFF_FFFC, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, BLTZAL, 32'hFFFF_FFFF, 16'h0020, 32'h0000_3000, 1'b0, 1'b0);
        checkOutput("stall_in_ready", {68'd0, bus.in_ready}, 69'd0);
        checkOutput("wrap_link", {37'd0, bus.out_link_value}, 69'd4);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd1, 16'd1, 32'h0000_3004, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd1, 16'd1, 32'h0000_3004, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd1, 16'd1, 32'h0000_3004, 1'b1, 1'b0);
        idle(2, 1'b1);

        $display("[TB] directed: flush with slot pending");
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 16'd0, 32'h0000_4000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, BGEZL, 32'hFFFF_FFFD, 16'h0008, 32'h0000_4004, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 16'd0, 32'h0000_4008, 1'b0, 1'b1);
        checkOutput("flush_valid", {68'd0, bus.out_valid}, 69'd0);
        issue(1'b0, 5'd0, 32'd0, 16'd0, 32'h0000_400C);
        checkOutput("flush_nokill", {68'd0, bus.out_kill}, 69'd0);
        idle(1, 1'b1);

        $display("[TB] directed: asynchronous reset");
        applyStimulus(1'b1, 1'b1, BGEZALL, 32'd9, 16'h0100, 32'h0000_5000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, TNEI, 32'd9, 16'h0009, 32'h0000_5004, 1'b0, 1'b0);
        #2;
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checkOutput("areset_fields", readOut(), '0);
        checkOutput("areset_valid", {68'd0, bus.out_valid}, 69'd0);
        checkOutput("areset_ready", {68'd0, bus.in_ready}, 69'd1);
        expq.delete();
        slotOpen = 1'b0;
        slotKill = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 5'd0, 32'd0, 16'd0, 32'h0000_6000);
        checkOutput("post_reset_kill", {68'd0, bus.out_kill}, 69'd0);

        $display("[TB] random phase");
        for (int i = 0; i < 800; i++) begin
            pick = $urandom_range(0, 19);
            if (pick < 14) begin
                rRt = codes[pick];
            end else begin
                tmp = $urandom;
                rRt = tmp[4:0];
            end
            case ($urandom_range(0, 7))
                0:       rImm = 16'hFFFF;
                1:       rImm = 16'h8000;
                2:       rImm = 16'h7FFF;
                3:       rImm = 16'h0000;
                default: begin tmp = $urandom; rImm = tmp[15:0]; end
            endcase
            sext = {{16{rImm[15]}}, rImm};
            case ($urandom_range(0, 7))
                0:       rRs = 32'd0;
                1:       rRs = 32'hFFFF_FFFF;
                2:       rRs = 32'h8000_0000;
                3:       rRs = 32'h7FFF_FFFF;
                4:       rRs = sext;
                5:       rRs = sext + 32'd1;
                6:       rRs = sext - 32'd1;
                default: rRs = $urandom;
            endcase
            tmp = $urandom;
            rPc = ($urandom_range(0, 7) == 0) ? {28'hFFFF_FFF, tmp[3:2], 2'b00}
                                              : {tmp[31:2], 2'b00};
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0,
                          rRt, rRs, rImm, rPc,
                          $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
        end

        idle(4, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
